dma_channel_scheduler: RTL and testbench

//  Shares one 2D DMA burst generator among NUM_CH requesting channels.

---
 rtl/dma_sched_pkg.sv | 29 ++
 rtl/dma_rr_arbiter.sv | 46 ++++
 rtl/dma_channel_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sched_pkg.sv
// Shared definitions for the DMA channel scheduler.
//  - dma_sched_state_t : scheduler FSM state encoding (3 bits)
//  - REQUIRED_BITWIDTH_UNSIGNED : bits needed to hold an unsigned value,
//    used to size the channel index from NUM_CH-1.
package dma_sched_pkg;

   localparam int BW_SCHED_STATE = 3;

   typedef enum logic [BW_SCHED_STATE-1:0] {
      DMA_SCHED_IDLE = 3'd0,
      DMA_SCHED_ARB  = 3'd1,
      DMA_SCHED_LOAD = 3'd2,
      DMA_SCHED_RUN  = 3'd3,
      DMA_SCHED_DONE = 3'd4
   } dma_sched_state_t;

   // Minimum of one bit so that a single-value range still yields a usable width.
   function automatic int REQUIRED_BITWIDTH_UNSIGNED(input int value);
      int bw;
      bw = 1;
      for (int i = 1; i < 31; i++) begin
         if ((value >> i) != 0) begin
            bw = i + 1;
         end
      end
      return bw;
   endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin arbiter.
//  Searches req starting at ptr and wrapping modulo NUM_CH; the first set
//  bit wins.
// Ports:
//  req    in   NUM_CH   request vector
//  ptr    in   BW_IDX   highest-priority channel for this decision
//  grant  out  NUM_CH   one-hot winner (0 when no request)
//  idx    out  BW_IDX   index of the winner (0 when no request)
//  valid  out  1        at least one request present
module dma_rr_arbiter
   import dma_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int BW_IDX = REQUIRED_BITWIDTH_UNSIGNED(NUM_CH - 1)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [BW_IDX-1:0] ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [BW_IDX-1:0] idx,
   output logic              valid
);

   always_comb begin
      int               cand;
      logic [BW_IDX-1:0] cand_idx;
      grant    = '0;
      idx      = '0;
      valid    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         // ptr is always < NUM_CH, so a single subtraction performs the wrap.
         cand = int'(ptr) + i;
         if (cand >= NUM_CH) begin
            cand = cand - NUM_CH;
         end
         cand_idx = cand[BW_IDX-1:0];
         if (!valid && req[cand_idx]) begin
            valid           = 1'b1;
            grant[cand_idx] = 1'b1;
            idx             = cand_idx;
         end
      end
   end

endmodule

// File: rtl/dma_channel_scheduler.sv
// DMA channel scheduler: shares one 2D burst generator among NUM_CH channels.
//  Grants round-robin, latches the winner's descriptor, starts the generator,
//  waits for its finish handshake and returns a one-cycle per-channel done.
// Ports:
//  clk, rstnn                    clock, synchronous active-low reset
//  ch_req                        level request per channel (held until ch_done)
//  ch_addr/line_size/num_lines/stride  packed per-channel descriptors, ch0 at LSB
//  ch_grant                      one-hot owner, LOAD through DONE
//  ch_done                       one-cycle completion pulse
//  sched_pause                   blocks new grants, stalls the running transfer
//  gen_start                     one-cycle generator start
//  gen_addr/line_size/num_lines/stride  latched descriptor of the owner
//  gen_stall                     sched_pause while the generator runs
//  gen_finish                    generator's last-beat handshake
//  ch_done_cnt (optional)        per-channel 8-bit wrapping done counters,
//                                present only when DMA_SCHED_DONE_CNT_EN is defined
module dma_channel_scheduler
   import dma_sched_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int BW_ADDR      = 32,
   parameter int BW_LINE_SIZE = 16,
   parameter int BW_NUM_LINES = 16
) (
   input  logic                           clk,
   input  logic                           rstnn,
   input  logic [NUM_CH-1:0]              ch_req,
   input  logic [NUM_CH*BW_ADDR-1:0]      ch_addr,
   input  logic [NUM_CH*BW_LINE_SIZE-1:0] ch_line_size,
   input  logic [NUM_CH*BW_NUM_LINES-1:0] ch_num_lines,
   input  logic [NUM_CH*BW_ADDR-1:0]      ch_stride,
   output logic [NUM_CH-1:0]              ch_grant,
   output logic [NUM_CH-1:0]              ch_done,
   input  logic                           sched_pause,
   output logic                           gen_start,
   output logic [BW_ADDR-1:0]             gen_addr,
   output logic [BW_LINE_SIZE-1:0]        gen_line_size,
   output logic [BW_NUM_LINES-1:0]        gen_num_lines,
   output logic [BW_ADDR-1:0]             gen_stride,
   output logic                           gen_stall,
   input  logic                           gen_finish
`ifdef DMA_SCHED_DONE_CNT_EN
   ,
   output logic [NUM_CH*8-1:0]            ch_done_cnt
`endif
);

   localparam int BW_IDX = REQUIRED_BITWIDTH_UNSIGNED(NUM_CH - 1);

   dma_sched_state_t        state_reg, state_next;
   logic [BW_IDX-1:0]       rr_ptr_reg;
   logic [BW_IDX-1:0]       idx_reg;
   logic [NUM_CH-1:0]       grant_reg;
   logic [BW_ADDR-1:0]      addr_reg;
   logic [BW_LINE_SIZE-1:0] line_size_reg;
   logic [BW_NUM_LINES-1:0] num_lines_reg;
   logic [BW_ADDR-1:0]      stride_reg;

   logic [NUM_CH-1:0]       arb_grant;
   logic [BW_IDX-1:0]       arb_idx;
   logic                    arb_valid;
   logic                    desc_zero;

   // Unpack the flat descriptor buses so the winner can be selected by index.
   logic [BW_ADDR-1:0]      addr_arr      [NUM_CH];
   logic [BW_LINE_SIZE-1:0] line_size_arr [NUM_CH];
   logic [BW_NUM_LINES-1:0] num_lines_arr [NUM_CH];
   logic [BW_ADDR-1:0]      stride_arr    [NUM_CH];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_arr[gi]      = ch_addr[gi*BW_ADDR +: BW_ADDR];
      assign line_size_arr[gi] = ch_line_size[gi*BW_LINE_SIZE +: BW_LINE_SIZE];
      assign num_lines_arr[gi] = ch_num_lines[gi*BW_NUM_LINES +: BW_NUM_LINES];
      assign stride_arr[gi]    = ch_stride[gi*BW_ADDR +: BW_ADDR];
   end

   // Requests are re-sampled in ARB, so the arbiter always sees live ch_req.
   dma_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .BW_IDX (BW_IDX)
   ) u_arb (
      .req   (ch_req),
      .ptr   (rr_ptr_reg),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign desc_zero = (line_size_reg == '0) || (num_lines_reg == '0);

   always_ff @(posedge clk) begin
      if (!rstnn) begin
         state_reg     <= DMA_SCHED_IDLE;
         rr_ptr_reg    <= '0;
         idx_reg       <= '0;
         grant_reg     <= '0;
         addr_reg      <= '0;
         line_size_reg <= '0;
         num_lines_reg <= '0;
         stride_reg    <= '0;
      end else begin
         state_reg <= state_next;
         // Descriptor is captured once per transfer; later register-file
         // writes cannot disturb the running transfer.
         if (state_reg == DMA_SCHED_ARB && arb_valid) begin
            idx_reg       <= arb_idx;
            grant_reg     <= arb_grant;
            addr_reg      <= addr_arr[arb_idx];
            line_size_reg <= line_size_arr[arb_idx];
            num_lines_reg <= num_lines_arr[arb_idx];
            stride_reg    <= stride_arr[arb_idx];
         end
         // The served channel becomes lowest priority for the next decision.
         if (state_reg == DMA_SCHED_DONE) begin
            if (idx_reg == BW_IDX'(NUM_CH - 1)) begin
               rr_ptr_reg <= '0;
            end else begin
               rr_ptr_reg <= idx_reg + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ch_grant   = '0;
      ch_done    = '0;
      gen_start  = 1'b0;
      gen_stall  = 1'b0;
      case (state_reg)
         DMA_SCHED_IDLE: begin
            if (|ch_req && !sched_pause) begin
               state_next = DMA_SCHED_ARB;
            end
         end
         DMA_SCHED_ARB: begin
            if (arb_valid) begin
               state_next = DMA_SCHED_LOAD;
            end else begin
               state_next = DMA_SCHED_IDLE;
            end
         end
         DMA_SCHED_LOAD: begin
            ch_grant = grant_reg;
            // Pause does not suppress the start; it only stalls RUN.
            if (desc_zero) begin
               state_next = DMA_SCHED_DONE;
            end else begin
               gen_start  = 1'b1;
               state_next = DMA_SCHED_RUN;
            end
         end
         DMA_SCHED_RUN: begin
            ch_grant  = grant_reg;
            gen_stall = sched_pause;
            if (gen_finish) begin
               state_next = DMA_SCHED_DONE;
            end
         end
         DMA_SCHED_DONE: begin
            ch_grant   = grant_reg;
            ch_done    = grant_reg;
            state_next = DMA_SCHED_IDLE;
         end
         default: begin
            state_next = DMA_SCHED_IDLE;
         end
      endcase
   end

   assign gen_addr      = addr_reg;
   assign gen_line_size = line_size_reg;
   assign gen_num_lines = num_lines_reg;
   assign gen_stride    = stride_reg;

`ifdef DMA_SCHED_DONE_CNT_EN
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_done_cnt
      logic [7:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (!rstnn) begin
            cnt_reg <= '0;
         end else if (ch_done[gi]) begin
            cnt_reg <= cnt_reg + 8'd1;
         end
      end
      assign ch_done_cnt[gi*8 +: 8] = cnt_reg;
   end
`endif

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Self-checking bench for dma_channel_scheduler (NUM_CH=4, default widths).
// Expected generator starts and channel dones are queued when a transfer is
// requested and compared by a monitor when the DUT produces them.
module tb_dma_channel_scheduler;

   localparam int NUM_CH = 4;

   typedef struct {
      logic [3:0]  grant;
      logic [31:0] addr;
      logic [15:0] line_size;
      logic [15:0] num_lines;
      logic [31:0] stride;
   } start_t;

   logic                 clk;
   logic                 rstnn;
   logic [NUM_CH-1:0]    ch_req;
   logic [NUM_CH*32-1:0] ch_addr;
   logic [NUM_CH*16-1:0] ch_line_size;
   logic [NUM_CH*16-1:0] ch_num_lines;
   logic [NUM_CH*32-1:0] ch_stride;
   logic [NUM_CH-1:0]    ch_grant;
   logic [NUM_CH-1:0]    ch_done;
   logic                 sched_pause;
   logic                 gen_start;
   logic [31:0]          gen_addr;
   logic [15:0]          gen_line_size;
   logic [15:0]          gen_num_lines;
   logic [31:0]          gen_stride;
   logic                 gen_stall;
   logic                 gen_finish;
`ifdef DMA_SCHED_DONE_CNT_EN
   logic [NUM_CH*8-1:0]  ch_done_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   start_t     exp_start_q [$];
   logic [3:0] exp_done_q  [$];

   bit gen_auto     = 1'b0;
   int finish_delay = 3;
   int gen_cnt      = 0;

   dma_channel_scheduler #(
      .NUM_CH       (NUM_CH),
      .BW_ADDR      (32),
      .BW_LINE_SIZE (16),
      .BW_NUM_LINES (16)
   ) dut (
      .clk           (clk),
      .rstnn         (rstnn),
      .ch_req        (ch_req),
      .ch_addr       (ch_addr),
      .ch_line_size  (ch_line_size),
      .ch_num_lines  (ch_num_lines),
      .ch_stride     (ch_stride),
      .ch_grant      (ch_grant),
      .ch_done       (ch_done),
      .sched_pause   (sched_pause),
      .gen_start     (gen_start),
      .gen_addr      (gen_addr),
      .gen_line_size (gen_line_size),
      .gen_num_lines (gen_num_lines),
      .gen_stride    (gen_stride),
      .gen_stall     (gen_stall),
      .gen_finish    (gen_finish)
`ifdef DMA_SCHED_DONE_CNT_EN
      ,
      .ch_done_cnt   (ch_done_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_desc(input int ch, input logic [31:0] a, input logic [15:0] ls,
                           input logic [15:0] nl, input logic [31:0] st);
      ch_addr[ch*32 +: 32]      = a;
      ch_line_size[ch*16 +: 16] = ls;
      ch_num_lines[ch*16 +: 16] = nl;
      ch_stride[ch*32 +: 32]    = st;
   endtask

   // Queue the expected outcome of one transfer on channel ch.
   task automatic push_xfer(input int ch, input bit with_start);
      start_t s;
      s.grant     = 4'b0001 << ch;
      s.addr      = ch_addr[ch*32 +: 32];
      s.line_size = ch_line_size[ch*16 +: 16];
      s.num_lines = ch_num_lines[ch*16 +: 16];
      s.stride    = ch_stride[ch*32 +: 32];
      if (with_start) exp_start_q.push_back(s);
      exp_done_q.push_back(s.grant);
   endtask

   task automatic wait_done(input int budget);
      int  i;
      bit  got;
      i   = 0;
      got = 1'b0;
      while (!got && i < budget) begin
         tick();
         i++;
         if (ch_done != '0) got = 1'b1;
      end
      if (!got) check_val("timeout_done", 0, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_grant"}, ch_grant, 0);
      check_val({tag, "_done"}, ch_done, 0);
      check_val({tag, "_start"}, gen_start, 0);
      check_val({tag, "_stall"}, gen_stall, 0);
      check_val({tag, "_addr"}, gen_addr, 0);
      check_val({tag, "_ls"}, gen_line_size, 0);
      check_val({tag, "_nl"}, gen_num_lines, 0);
      check_val({tag, "_stride"}, gen_stride, 0);
   endtask

   // Zero-size transfer: no start, done two cycles after ARB.
   task automatic zero_xfer(input int ch, input string tag);
      push_xfer(ch, 1'b0);
      ch_req = 4'b0001 << ch;
      tick();                                    // ARB
      check_val({tag, "_arb_grant"}, ch_grant, 0);
      tick();                                    // LOAD
      check_val({tag, "_load_start"}, gen_start, 0);
      check_val({tag, "_load_grant"}, ch_grant, 4'b0001 << ch);
      tick();                                    // DONE
      check_val({tag, "_done"}, ch_done, 4'b0001 << ch);
      ch_req = '0;
      tick();
   endtask

   // Behavioural burst generator: finish_delay cycles after a start, one-cycle finish.
   initial begin
      gen_finish = 1'b0;
      forever begin
         tick();
         if (gen_auto) begin
            gen_finish = 1'b0;
            if (!rstnn) begin
               gen_cnt = 0;
            end else if (gen_cnt != 0) begin
               gen_cnt--;
               if (gen_cnt == 0) gen_finish = 1'b1;
            end else if (gen_start) begin
               gen_cnt = finish_delay;
            end
         end
      end
   end

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      start_t     s;
      logic [3:0] d;
      if (gen_start) begin
         if (exp_start_q.size() == 0) begin
            check_val("sb_start_unexpected", 1, 0);
         end else begin
            s = exp_start_q.pop_front();
            check_val("sb_start_grant", ch_grant, s.grant);
            check_val("sb_start_addr", gen_addr, s.addr);
            check_val("sb_start_ls", gen_line_size, s.line_size);
            check_val("sb_start_nl", gen_num_lines, s.num_lines);
            check_val("sb_start_stride", gen_stride, s.stride);
            $display("start grant=%b addr=0x%0h ls=%0d nl=%0d stride=0x%0h",
                     ch_grant, gen_addr, gen_line_size, gen_num_lines, gen_stride);
         end
      end
      if (ch_done != '0) begin
         check_val("sb_done_vs_grant", ch_done, ch_grant);
         if (exp_done_q.size() == 0) begin
            check_val("sb_done_unexpected", 1, 0);
         end else begin
            d = exp_done_q.pop_front();
            check_val("sb_done_ch", ch_done, d);
            if (exp_done_q.size() < 4)
               $display("done ch_done=%b", ch_done);
         end
      end
   end

   initial begin
      int fin_c;
      int done_c;
      rstnn        = 1'b0;
      ch_req       = '0;
      sched_pause  = 1'b0;
      ch_addr      = '0;
      ch_line_size = '0;
      ch_num_lines = '0;
      ch_stride    = '0;

      // Reset state
      tick();
      tick();
      check_idle_outputs("reset");
      rstnn = 1'b1;
      tick();

      // 1: single request on ch2
      set_desc(2, 32'h1000, 16'd64, 16'd4, 32'h100);
      push_xfer(2, 1'b1);
      gen_auto     = 1'b1;
      finish_delay = 3;
      ch_req       = 4'b0100;
      tick();                                    // ARB
      check_val("t1_arb_grant", ch_grant, 0);
      check_val("t1_arb_start", gen_start, 0);
      tick();                                    // LOAD
      check_val("t1_load_start", gen_start, 1);
      check_val("t1_load_grant", ch_grant, 4'b0100);
      fin_c  = -1;
      done_c = -1;
      for (int i = 0; i < 20 && done_c < 0; i++) begin
         tick();
         if (gen_finish) fin_c = i;
         if (ch_done != '0) done_c = i;
      end
      check_val("t1_done_seen", done_c >= 0, 1);
      check_val("t1_finish_to_done", done_c - fin_c, 1);
      check_val("t1_done_vec", ch_done, 4'b0100);
      ch_req = '0;
      tick();
      check_val("t1_idle_grant", ch_grant, 0);

      // 2: all four channels held, round-robin from ch0
      rstnn = 1'b0;
      tick();
      rstnn = 1'b1;
      for (int c = 0; c < NUM_CH; c++)
         set_desc(c, 32'h2000 + 32'(c) * 32'h40, 16'd16 + 16'(c), 16'd2 + 16'(c), 32'h80);
      finish_delay = 5;
      push_xfer(0, 1'b1);
      push_xfer(1, 1'b1);
      push_xfer(2, 1'b1);
      push_xfer(3, 1'b1);
      push_xfer(0, 1'b1);
      ch_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_done(40);
         if (k == 4) ch_req = '0;
      end
      tick();

      // 3: zero-size descriptors on ch1, then rr_ptr must have moved to 2
      set_desc(1, 32'h3000, 16'd32, 16'd0, 32'h10);
      zero_xfer(1, "t3_nl0");
      push_xfer(0, 1'b1);
      ch_req = 4'b0011;                          // ptr 2 -> ch0 wins
      wait_done(40);
      ch_req = '0;
      tick();
      set_desc(1, 32'h3000, 16'd0, 16'd3, 32'h10);
      zero_xfer(1, "t3_ls0");

      // 4: pause during RUN, then pause blocking a new grant in IDLE
      gen_auto = 1'b0;
      set_desc(0, 32'h4000, 16'd8, 16'd8, 32'h200);
      set_desc(3, 32'h5000, 16'd4, 16'd1, 32'h0);
      push_xfer(0, 1'b1);
      push_xfer(3, 1'b1);
      ch_req = 4'b0001;
      tick();                                    // ARB
      tick();                                    // LOAD
      tick();                                    // RUN
      sched_pause = 1'b1;
      ch_req      = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("t4_stall", gen_stall, 1);
         check_val("t4_grant_held", ch_grant, 4'b0001);
      end
      sched_pause = 1'b0;
      tick();
      check_val("t4_unstall", gen_stall, 0);
      gen_finish = 1'b1;
      tick();                                    // DONE
      gen_finish = 1'b0;
      check_val("t4_done0", ch_done, 4'b0001);
      ch_req      = 4'b1000;
      sched_pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         gen_finish = (i == 1);                  // ignored outside RUN
         tick();
         check_val("t4_pause_idle_grant", ch_grant, 0);
      end
      gen_finish   = 1'b0;
      sched_pause  = 1'b0;
      gen_auto     = 1'b1;
      finish_delay = 2;
      wait_done(40);
      check_val("t4_done3", ch_done, 4'b1000);
      ch_req = '0;
      tick();

      // 5: reset mid-RUN; held request regranted from ch0
      set_desc(1, 32'h6000, 16'd2, 16'd2, 32'h4);
      push_xfer(1, 1'b1);                        // moves rr_ptr to 2
      ch_req = 4'b0010;
      wait_done(40);
      ch_req = '0;
      tick();
      gen_auto = 1'b0;
      set_desc(3, 32'h7000, 16'd6, 16'd6, 32'h8);
      set_desc(0, 32'h8000, 16'd12, 16'd3, 32'h30);
      push_xfer(3, 1'b1);                        // aborted: start only
      exp_done_q.delete(exp_done_q.size() - 1);
      ch_req = 4'b1000;
      tick();                                    // ARB
      tick();                                    // LOAD
      tick();                                    // RUN
      rstnn = 1'b0;
      tick();
      check_idle_outputs("t5_reset");
      rstnn  = 1'b1;
      ch_req = 4'b1011;
      push_xfer(0, 1'b1);
      gen_auto     = 1'b1;
      finish_delay = 2;
      tick();                                    // ARB
      tick();                                    // LOAD
      check_val("t5_regrant", ch_grant, 4'b0001);
      wait_done(40);
      ch_req = '0;
      tick();

`ifdef DMA_SCHED_DONE_CNT_EN
      // 6: 260 transfers on ch0 -> 8-bit counter wraps to 4
      rstnn = 1'b0;
      tick();
      rstnn = 1'b1;
      check_val("t6_cnt_reset", ch_done_cnt, 0);
      finish_delay = 1;
      set_desc(0, 32'h9000, 16'd1, 16'd1, 32'h0);
      for (int n = 0; n < 260; n++) begin
         push_xfer(0, 1'b1);
         ch_req = 4'b0001;
         wait_done(20);
         ch_req = '0;
      end
      tick();
      check_val("t6_cnt_ch0", ch_done_cnt[7:0], 8'd4);
      check_val("t6_cnt_others", ch_done_cnt[31:8], 0);
`endif

      tick();
      tick();
      check_val("sb_start_left", exp_start_q.size(), 0);
      check_val("sb_done_left", exp_done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
